// File: rtl/dsp48a1_ctrl_pkg.sv
// Shared types and constants for the DSP48A1 dot-product controller.
//   state_e   : controller FSM states
//   res_t     : latched frame result (accumulated P + sticky carry-out)
//   OPM_*     : opmode words driven to the slice
//   DSP_*_W   : slice port widths
package dsp48a1_ctrl_pkg;

  localparam int DSP_AB_W = 18;
  localparam int DSP_M_W  = 36;
  localparam int DSP_P_W  = 48;

  // X = M, Z = 0 : restart accumulation
  localparam logic [7:0] OPM_FIRST = 8'h01;
  // X = M, Z = P : accumulate
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DSP_P_W-1:0] data;
    logic               ovf;
  } res_t;

endpackage

// File: rtl/dsp48a1_pipe_tag.sv
// 1-bit shift register of parameterised depth with async active-low clear.
// Tracks which slice pipeline slots hold a real sample.
//   clk_i  : clock
//   rst_ni : async active-low clear
//   d_i    : tag entering the pipe (1 = real sample this cycle)
//   q_o    : tag leaving the pipe after DEPTH edges
module dsp48a1_pipe_tag #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] vld_pipe_q;
  logic [DEPTH:0]   vld_chain;

  assign vld_chain = {vld_pipe_q, d_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe_q <= '0;
    else         vld_pipe_q <= vld_chain[DEPTH-1:0];
  end

  assign q_o = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Initiator-side controller driving one DSP48A1 slice as a dot-product MAC.
// Slice setup: A1REG=B1REG=MREG=PREG=OPMODEREG=CARRYOUTREG=1, B direct.
//   start_*  : frame request (length, 0 allowed), accepted only in IDLE
//   in_*     : stream of signed 18-bit operand pairs, accepted only in RUN
//   res_*    : 48-bit accumulated P plus sticky carry-out flag
//   busy_o   : high whenever not IDLE
//   dsp_*_o  : registered A/B/OPMODE plus CE/RST to the slice
//   dsp_p_i, dsp_carryout_i : slice registered outputs
module dsp48a1_mac_ctrl
  import dsp48a1_ctrl_pkg::*;
#(
  parameter int LEN_W      = 10,
  parameter int PIPE_LAT   = 3,
  parameter int OPMODE_DLY = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_valid_i,
  output logic                start_ready_o,
  input  logic [LEN_W-1:0]    start_len_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DSP_AB_W-1:0] in_a_i,
  input  logic [DSP_AB_W-1:0] in_b_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DSP_P_W-1:0]  res_data_o,
  output logic                res_ovf_o,
  output logic                busy_o,
  output logic [DSP_AB_W-1:0] dsp_a_o,
  output logic [DSP_AB_W-1:0] dsp_b_o,
  output logic [7:0]          dsp_opmode_o,
  output logic                dsp_ce_o,
  output logic                dsp_rst_o,
  input  logic [DSP_P_W-1:0]  dsp_p_i,
  input  logic                dsp_carryout_i
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                first_q, first_d;
  logic                ovf_q, ovf_d;
  res_t                res_q, res_d;
  logic                res_valid_q, res_valid_d;
  logic [DSP_AB_W-1:0] dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d;
  // opmode belonging to the sample presented on dsp_a/b this cycle
  logic [7:0]          opm_now_q, opm_now_d;

  logic accept, last_acc, tag_out, last_out;

  assign start_ready_o = (state_q == IDLE);
  assign in_ready_o    = (state_q == RUN) && (cnt_q < len_q);
  assign busy_o        = (state_q != IDLE);
  assign accept        = in_valid_i && in_ready_o;
  assign last_acc      = accept && ((cnt_q + LEN_W'(1)) == len_q);

  assign dsp_ce_o  = rst_n_i;
  assign dsp_rst_o = ~rst_n_i;

  // Tag pipe lines up with the cycle DSP_P/CARRYOUT reflect a sample,
  // so carry-out is only sampled for real samples, never bubbles.
  dsp48a1_pipe_tag #(.DEPTH(PIPE_LAT + 1)) u_tag_smp (
    .clk_i  (clk_i),
    .rst_ni (rst_n_i),
    .d_i    (accept),
    .q_o    (tag_out)
  );

  // Second tag marks only the last sample: its arrival ends the drain.
  dsp48a1_pipe_tag #(.DEPTH(PIPE_LAT + 1)) u_tag_last (
    .clk_i  (clk_i),
    .rst_ni (rst_n_i),
    .d_i    (last_acc),
    .q_o    (last_out)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    opm_now_d   = 8'h00;
    dsp_a_d     = '0;
    dsp_b_d     = '0;

    if (accept) begin
      dsp_a_d = in_a_i;
      dsp_b_d = in_b_i;
      cnt_d   = cnt_q + LEN_W'(1);
      first_d = 1'b0;
    end
    if (tag_out) ovf_d = ovf_q | dsp_carryout_i;

    unique case (state_q)
      IDLE: begin
        if (start_valid_i) begin
          len_d   = start_len_i;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          first_d = 1'b1;
          if (start_len_i == '0) begin
            res_d       = '0;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            opm_now_d = OPM_FIRST;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        // first_q is still set on the first acceptance edge
        opm_now_d = first_q ? OPM_FIRST : OPM_ACC;
        if (last_acc) state_d = DRAIN;
      end
      DRAIN: begin
        opm_now_d = OPM_ACC;
        if (last_out) begin
          res_d.data  = dsp_p_i;
          res_d.ovf   = ovf_d;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opm_now_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      opm_now_q   <= opm_now_d;
    end
  end

  // Slice registers OPMODE one stage later than A/B, so the opmode is
  // delayed to meet its sample at the P adder.
  if (OPMODE_DLY == 0) begin : g_opm_nodly
    assign dsp_opmode_o = opm_now_q;
  end else begin : g_opm_dly
    logic [OPMODE_DLY-1:0][7:0] opm_dly_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        opm_dly_q <= '0;
      end else begin
        opm_dly_q[0] <= opm_now_q;
        for (int i = 1; i < OPMODE_DLY; i++) opm_dly_q[i] <= opm_dly_q[i-1];
      end
    end
    assign dsp_opmode_o = opm_dly_q[OPMODE_DLY-1];
  end

  assign dsp_a_o     = dsp_a_q;
  assign dsp_b_o     = dsp_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_q.data;
  assign res_ovf_o   = res_q.ovf;

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Bench for dsp48a1_mac_ctrl with a behavioural DSP48A1 slice model
// (A1/B1/M/P/OPMODE/CARRYOUT registered, synchronous RST, CE).
module tb_dsp48a1_mac_ctrl;
  import dsp48a1_ctrl_pkg::*;

  localparam int LEN_W = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid, start_ready, in_valid, in_ready;
  logic [LEN_W-1:0] start_len;
  logic [17:0] in_a, in_b, dsp_a, dsp_b;
  logic        res_valid, res_ready, res_ovf, busy, dsp_ce, dsp_rst;
  logic [47:0] res_data, dsp_p;
  logic [7:0]  dsp_opmode;
  logic        dsp_co;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp48a1_mac_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(3), .OPMODE_DLY(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready), .start_len_i(start_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_ovf_o(res_ovf),
    .busy_o(busy), .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_opmode_o(dsp_opmode),
    .dsp_ce_o(dsp_ce), .dsp_rst_o(dsp_rst), .dsp_p_i(dsp_p), .dsp_carryout_i(dsp_co)
  );

  // ---- slice model ----
  logic [17:0] a1_q, b1_q;
  logic [35:0] m_q, ax, bx, prod;
  logic [7:0]  opm_q;
  logic [47:0] p_q, x_mux, z_mux;
  logic        co_q;
  logic [48:0] sum;

  always_comb begin
    ax    = {{18{a1_q[17]}}, a1_q};
    bx    = {{18{b1_q[17]}}, b1_q};
    prod  = ax * bx;
    x_mux = (opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
    z_mux = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
    sum   = {1'b0, x_mux} + {1'b0, z_mux};
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      a1_q <= '0; b1_q <= '0; m_q <= '0; opm_q <= '0; p_q <= '0; co_q <= 1'b0;
    end else if (dsp_ce) begin
      a1_q  <= dsp_a;
      b1_q  <= dsp_b;
      m_q   <= prod;
      opm_q <= dsp_opmode;
      p_q   <= sum[47:0];
      co_q  <= sum[48];
    end
  end
  assign dsp_p  = p_q;
  assign dsp_co = co_q;

  // ---- helpers ----
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start_frame(input int len);
    int n = 0;
    start_valid = 1'b1;
    start_len   = LEN_W'(len);
    while (!start_ready && n < 20) begin tick(); n++; end
    tick();
    start_valid = 1'b0;
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    if (in_ready) begin
      tick();
      last_acc = cyc;
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
  endtask

  task automatic wait_result(output int lat);
    int n = 0;
    while (!res_valid && n < 30) begin tick(); n++; end
    chk("res_valid_wait", 64'(res_valid), 64'd1);
    lat = cyc - last_acc;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_hs", 64'(start_ready), 64'd1);
    chk("busy_after_hs", 64'(busy), 64'd0);
  endtask

  typedef struct {
    int              len;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0]     data;
    logic            ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    vecs[0] = '{4, {18'd7, 18'd5, 18'd3, 18'd1}, {18'd8, 18'd6, 18'd4, 18'd2},
                48'd100, 1'b0};
    vecs[1] = '{2, {18'd0, 18'd0, 18'd2, 18'h3FFFD}, {18'd0, 18'd0, 18'h3FFF9, 18'd5},
                48'hFFFF_FFFF_FFE3, 1'b1};
    vecs[2] = '{1, {18'd0, 18'd0, 18'd0, 18'd6}, {18'd0, 18'd0, 18'd0, 18'd7},
                48'd42, 1'b0};
    vecs[3] = '{3, {18'd0, 18'd1, 18'd1, 18'd1}, {18'd0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
                48'hFFFF_FFFF_FFFD, 1'b1};
    vecs[4] = '{3, {18'd0, 18'h20000, 18'h20000, 18'h1FFFF},
                {18'd0, 18'h1FFFF, 18'h20000, 18'h1FFFF},
                48'h0003_FFFE_0001, 1'b1};

    start_valid = 0; start_len = '0; in_valid = 0; in_a = '0; in_b = '0; res_ready = 0;

    // reset
    tick(); tick();
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("rst_dsp_ce", 64'(dsp_ce), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("run_dsp_ce", 64'(dsp_ce), 64'd1);
    chk("run_dsp_rst", 64'(dsp_rst), 64'd0);

    // table-driven back-to-back frames
    for (int i = 0; i < 5; i++) begin
      start_frame(vecs[i].len);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      for (int j = 0; j < vecs[i].len; j++) send(vecs[i].a[j], vecs[i].b[j]);
      chk($sformatf("v%0d_in_ready_off", i), 64'(in_ready), 64'd0);
      wait_result(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("v%0d_data", i), 64'(res_data), 64'(vecs[i].data));
      chk($sformatf("v%0d_ovf", i), 64'(res_ovf), 64'(vecs[i].ovf));
      take_result();
    end

    // bubble between pairs 2 and 3
    start_frame(4);
    send(18'd1, 18'd2);
    chk("bub_opm_entry", 64'(dsp_opmode), 64'h01);
    send(18'd3, 18'd4);
    chk("bub_opm_first", 64'(dsp_opmode), 64'h01);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bub_dsp_a", 64'(dsp_a), 64'd0);
      chk("bub_dsp_b", 64'(dsp_b), 64'd0);
      chk("bub_opm", 64'(dsp_opmode), 64'h09);
    end
    send(18'd5, 18'd6);
    send(18'd7, 18'd8);
    wait_result(lat);
    chk("bub_latency", 64'(lat), 64'd4);
    chk("bub_data", 64'(res_data), 64'd100);
    chk("bub_ovf", 64'(res_ovf), 64'd0);
    take_result();

    // zero-length frame
    start_valid = 1'b1; start_len = '0;
    chk("len0_in_ready_pre", 64'(in_ready), 64'd0);
    tick();
    start_valid = 1'b0;
    chk("len0_res_valid", 64'(res_valid), 64'd1);
    chk("len0_data", 64'(res_data), 64'd0);
    chk("len0_ovf", 64'(res_ovf), 64'd0);
    chk("len0_in_ready", 64'(in_ready), 64'd0);
    take_result();

    // carry-out frame with result back-pressure
    start_frame(3);
    for (int j = 0; j < 3; j++) send(18'd1, 18'h3FFFF);
    wait_result(lat);
    chk("hold_ovf", 64'(res_ovf), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_data", 64'(res_data), 64'hFFFF_FFFF_FFFD);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_start_ready", 64'(start_ready), 64'd0);
    end
    take_result();

    // reset mid-frame, then a fresh frame
    start_frame(4);
    send(18'd1, 18'd2);
    send(18'd3, 18'd4);
    rst_n = 1'b0;
    #1;
    chk("abort_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("abort_dsp_a", 64'(dsp_a), 64'd0);
    chk("abort_opm", 64'(dsp_opmode), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    tick(); tick(); tick();
    chk("abort_no_result", 64'(res_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    start_frame(1);
    send(18'd6, 18'd7);
    wait_result(lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_data", 64'(res_data), 64'd42);
    chk("post_rst_ovf", 64'(res_ovf), 64'd0);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
